// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and default sizing for the APB round-robin master arbiter.
//   arb_state_e      : bus-sequencer state encoding
//   ARB_NUM_REQ_DEF  : default requester count
//   ARB_PTR_W        : pointer / grant-index width for the default count
//   arb_ptr_w()      : pointer width for an arbitrary requester count (min 1)
// ---------------------------------------------------------------------------
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_e;

  localparam int ARB_NUM_REQ_DEF = 4;
  localparam int ARB_PTR_W       = $clog2(ARB_NUM_REQ_DEF);

  function automatic int arb_ptr_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// Combinational round-robin grant. Searches the request vector starting at
// ptr and wrapping, returning the first set bit.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  PTR_W    highest-priority requester index
//   gnt_any out 1        at least one request set
//   gnt_oh  out NUM_REQ  one-hot grant (all zero when gnt_any=0)
//   gnt_idx out PTR_W    grant index (0 when gnt_any=0)
// ---------------------------------------------------------------------------
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEF,
  parameter int PTR_W   = ARB_PTR_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               gnt_any,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [PTR_W-1:0]   gnt_idx
);

  always_comb begin
    int cand;
    cand    = 0;
    gnt_any = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!gnt_any && req[cand]) begin
        gnt_any      = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_master_arbiter
// Shares one APB master port between NUM_REQ requesters with round-robin
// priority, sequences SETUP/ACCESS and returns the response to the owner.
// Optional feature macro: APB_ARB_TIMEOUT_EN -- aborts an ACCESS phase after
// TIMEOUT_CYC cycles without pready and reports it as a slave error.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_write         per-requester request and direction
//   req_addr/req_wdata          packed per-requester address / write data
//   req_ready                   one-cycle grant pulse
//   rsp_valid                   one-cycle completion pulse to the owner
//   rsp_rdata/rsp_slverr        completion data / error, valid with rsp_valid
//   paddr..pwdata               APB master outputs (all registered)
//   prdata/pready/pslverr       APB slave returns
// ---------------------------------------------------------------------------
// state      | meaning
// ARB_IDLE   | bus free, psel=0; arbitrate on any req_valid
// ARB_SETUP  | APB setup cycle, psel=1 penable=0, exactly one cycle
// ARB_ACCESS | psel=1 penable=1, fields held until pready (or timeout)
// ---------------------------------------------------------------------------
module apb_rr_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = ARB_NUM_REQ_DEF,
  parameter int APB_AW      = 32,
  parameter int APB_DW      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*APB_AW-1:0] req_addr,
  input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [APB_DW-1:0]         rsp_rdata,
  output logic                      rsp_slverr,
  output logic [APB_AW-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_DW-1:0]         pwdata,
  input  logic [APB_DW-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int PTR_W = arb_ptr_w(NUM_REQ);

  // Out-of-range configurations show up as this marker scope in the hierarchy.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_unsupported_cfg
  end

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [APB_AW-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [APB_DW-1:0]   pwdata_q, pwdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_slverr_q, rsp_slverr_d;

  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  owner_oh;
  logic                gnt_any;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    ptr_inc;
  logic [APB_AW-1:0]   gnt_addr;
  logic [APB_DW-1:0]   gnt_wdata;
  logic                gnt_write;
  logic                load_grant;
  logic                to_expired;

  assign owner_oh = NUM_REQ'(1) << owner_q;

  // The owner may still show req_valid in ACCESS only through a protocol
  // violation; masking it keeps back-to-back re-arbitration fair regardless.
  assign arb_req = (state_q == ARB_ACCESS) ? (req_valid & ~owner_oh) : req_valid;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt_any (gnt_any),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign gnt_addr  = req_addr[int'(gnt_idx)*APB_AW +: APB_AW];
  assign gnt_wdata = req_wdata[int'(gnt_idx)*APB_DW +: APB_DW];
  assign gnt_write = req_write[gnt_idx];
  assign ptr_inc   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Down-counter loaded on every grant (SETUP entry); terminal count 0 while
  // still in ACCESS means TIMEOUT_CYC ACCESS cycles have elapsed.
  assign to_expired = (to_cnt_q == '0);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (load_grant) begin
      to_cnt_d = TO_W'(TIMEOUT_CYC - 1);
    end else if (state_q == ARB_ACCESS && !to_expired) begin
      to_cnt_d = to_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
    load_grant   = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        load_grant = gnt_any;
      end
      ARB_SETUP: begin
        penable_d = 1'b1;
        state_d   = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        if (pready) begin
          rsp_valid_d  = owner_oh;
          rsp_rdata_d  = pwrite_q ? '0 : prdata;
          rsp_slverr_d = pslverr;
          penable_d    = 1'b0;
          if (gnt_any) begin
            load_grant = 1'b1;
          end else begin
            psel_d  = 1'b0;
            state_d = ARB_IDLE;
          end
        end else if (to_expired) begin
          rsp_valid_d  = owner_oh;
          rsp_rdata_d  = '0;
          rsp_slverr_d = 1'b1;
          penable_d    = 1'b0;
          psel_d       = 1'b0;
          state_d      = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (load_grant) begin
      paddr_d     = gnt_addr;
      pwrite_d    = gnt_write;
      pwdata_d    = gnt_write ? gnt_wdata : '0;
      psel_d      = 1'b1;
      req_ready_d = gnt_oh;
      owner_d     = gnt_idx;
      ptr_d       = ptr_inc;
      state_d     = ARB_SETUP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
    end
  end

  assign paddr      = paddr_q;
  assign pwrite     = pwrite_q;
  assign pwdata     = pwdata_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_master_arbiter
// Directed scenarios plus a randomized run against a transaction-level
// reference model of the round-robin APB master arbiter.
// ---------------------------------------------------------------------------
module tb_apb_rr_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_slverr;
  logic [AW-1:0]   paddr;
  logic            psel, penable, pwrite;
  logic [DW-1:0]   pwdata, prdata;
  logic            pready, pslverr;

  apb_rr_master_arbiter #(
    .NUM_REQ(N), .APB_AW(AW), .APB_DW(DW), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // slave behaviour knobs
  bit          slv_rand = 1'b0;
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  bit          slv_err = 1'b0;
  int          wait_left = 0;

  // APB slave: counts wait states from the SETUP cycle it observes.
  task automatic slave_update();
    if (!rst_n) begin
      pready = 1'b0; pslverr = 1'b0; prdata = '0; wait_left = 0;
    end else if (psel && !penable) begin
      if (slv_rand) begin
        slv_wait  = $urandom_range(0, 3);
        slv_rdata = $urandom;
        slv_err   = ($urandom_range(0, 3) == 0);
      end
      wait_left = slv_wait;
      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    end else if (psel && penable) begin
      if (wait_left == 0) begin
        pready = 1'b1; prdata = slv_rdata; pslverr = slv_err;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
        wait_left--;
      end
    end else begin
      pready = 1'b0; prdata = $urandom; pslverr = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slave_update();
  endtask

  task automatic issue(input int r, input bit w, input logic [31:0] a, input logic [31:0] d);
    req_write[r]        = w;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    req_valid[r]        = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    int best;
    int bd;
    best = -1;
    bd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d;
        d = (i - p + N) % N;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1; req_write = '1; req_addr = {4{32'hFFFF_0000}}; req_wdata = {4{32'h1234_5678}};
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if ({psel, penable, pwrite, req_ready, rsp_valid, rsp_slverr} !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_ctrl: got %h expected 000", {psel, penable, pwrite, req_ready, rsp_valid, rsp_slverr});
      end
      vectors++;
      if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
        miscompares++;
        $display("FAIL reset_data: got %h expected 0", {paddr, pwdata, rsp_rdata});
      end
    end
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    slv_rand = 1'b0; slv_wait = 0; slv_rdata = 32'hA5A5_0001; slv_err = 1'b0;
    issue(1, 1'b0, 32'h10, 32'hFFFF_FFFF);
    tick();
    vectors++;
    if ({psel, penable, req_ready, rsp_valid} !== 10'b1_0_0010_0000) begin
      miscompares++;
      $display("FAIL rd_setup: got %b expected 1000100000", {psel, penable, req_ready, rsp_valid});
    end
    vectors++;
    if ({paddr, pwrite, pwdata} !== {32'h10, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL rd_fields: got %h expected %h", {paddr, pwrite, pwdata}, {32'h10, 1'b0, 32'h0});
    end
    req_valid[1] = 1'b0;
    tick();
    vectors++;
    if ({psel, penable, rsp_valid} !== 6'b11_0000) begin
      miscompares++;
      $display("FAIL rd_access: got %b expected 110000", {psel, penable, rsp_valid});
    end
    tick();
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_slverr, psel, penable} !== {4'b0010, 32'hA5A5_0001, 3'b000}) begin
      miscompares++;
      $display("FAIL rd_rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_slverr, psel, penable},
               {4'b0010, 32'hA5A5_0001, 3'b000});
    end
    tick();
    vectors++;
    if (rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL rd_pulse: got %b expected 0000", rsp_valid);
    end
  endtask

  task automatic test_write_wait();
    slv_rand = 1'b0; slv_wait = 5; slv_rdata = 32'h1234_5678; slv_err = 1'b0;
    issue(2, 1'b1, 32'h20, 32'hDEAD_BEEF);
    tick();
    vectors++;
    if ({psel, penable, req_ready} !== 6'b10_0100) begin
      miscompares++;
      $display("FAIL wr_setup: got %b expected 100100", {psel, penable, req_ready});
    end
    req_valid[2] = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      vectors++;
      if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !== {3'b111, 32'h20, 32'hDEAD_BEEF, 4'b0000}) begin
        miscompares++;
        $display("FAIL wr_stable_%0d: got %h expected %h", t, {psel, penable, pwrite, paddr, pwdata, rsp_valid},
                 {3'b111, 32'h20, 32'hDEAD_BEEF, 4'b0000});
      end
    end
    tick();
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_slverr, psel} !== {4'b0100, 32'h0, 2'b00}) begin
      miscompares++;
      $display("FAIL wr_rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_slverr, psel}, {4'b0100, 32'h0, 2'b00});
    end
  endtask

  task automatic test_slverr();
    slv_rand = 1'b0; slv_wait = 0; slv_rdata = 32'h0BAD_0030; slv_err = 1'b1;
    issue(3, 1'b0, 32'h30, 32'h0);
    tick(); req_valid[3] = 1'b0;
    tick(); tick();
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_slverr} !== {4'b1000, 32'h0BAD_0030, 1'b1}) begin
      miscompares++;
      $display("FAIL err_rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_slverr}, {4'b1000, 32'h0BAD_0030, 1'b1});
    end
    slv_rdata = 32'h600D_0040; slv_err = 1'b0;
    issue(0, 1'b0, 32'h40, 32'h0);
    tick(); req_valid[0] = 1'b0;
    tick(); tick();
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_slverr} !== {4'b0001, 32'h600D_0040, 1'b0}) begin
      miscompares++;
      $display("FAIL err_next: got %h expected %h", {rsp_valid, rsp_rdata, rsp_slverr}, {4'b0001, 32'h600D_0040, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    int          ngnt, nrsp;
    int          cnt[N];
    bit          gap, en_wo_sel;
    seq = '0; ngnt = 0; nrsp = 0; gap = 1'b0; en_wo_sel = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    slv_rand = 1'b0; slv_wait = 0; slv_rdata = 32'h0000_0B2B; slv_err = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) issue(i, i[0], 32'h100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
    repeat (2) tick();
    rst_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          seq = {seq[11:0], 4'(i)};
          ngnt++;
          req_valid[i] = 1'b0;
        end
        if (rsp_valid[i]) begin cnt[i]++; nrsp++; end
      end
      if (ngnt > 0 && nrsp < N && !psel) gap = 1'b1;
      if (penable && !psel) en_wo_sel = 1'b1;
    end
    vectors++;
    if (seq !== 16'h0123 || ngnt != N) begin
      miscompares++;
      $display("FAIL b2b_order: got %h (%0d grants) expected 0123 (4 grants)", seq, ngnt);
    end
    vectors++;
    if ({cnt[0], cnt[1], cnt[2], cnt[3]} != {32'd1, 32'd1, 32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL b2b_rsp_count: got %0d %0d %0d %0d expected 1 1 1 1", cnt[0], cnt[1], cnt[2], cnt[3]);
    end
    vectors++;
    if ({gap, en_wo_sel} != 2'b00) begin
      miscompares++;
      $display("FAIL b2b_psel_held: got gap=%0d en_wo_sel=%0d expected 0 0", gap, en_wo_sel);
    end
  endtask

  task automatic test_reset_mid();
    bit got1;
    int nrsp;
    got1 = 1'b0; nrsp = 0;
    do_reset();
    slv_rand = 1'b0; slv_wait = 10; slv_rdata = 32'h0; slv_err = 1'b0;
    issue(0, 1'b0, 32'h50, 32'h0);
    tick(); req_valid[0] = 1'b0;
    tick();
    vectors++;
    if ({psel, penable} !== 2'b11) begin
      miscompares++;
      $display("FAIL rstmid_access: got %b expected 11", {psel, penable});
    end
    rst_n = 1'b0;
    for (int t = 0; t < 2; t++) begin
      tick();
      vectors++;
      if ({psel, penable, rsp_valid, req_ready} !== 10'h0) begin
        miscompares++;
        $display("FAIL rstmid_drop_%0d: got %b expected 0000000000", t, {psel, penable, rsp_valid, req_ready});
      end
    end
    rst_n = 1'b1;
    slv_wait = 0;
    issue(0, 1'b0, 32'h60, 32'h0);
    issue(1, 1'b0, 32'h64, 32'h0);
    tick();
    vectors++;
    if ({req_ready, paddr} !== {4'b0001, 32'h60}) begin
      miscompares++;
      $display("FAIL rstmid_ptr0: got %h expected %h", {req_ready, paddr}, {4'b0001, 32'h60});
    end
    req_valid[0] = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (req_ready[1]) begin got1 = 1'b1; req_valid[1] = 1'b0; end
      if (|rsp_valid) nrsp++;
    end
    vectors++;
    if (!got1 || nrsp != 2) begin
      miscompares++;
      $display("FAIL rstmid_drain: got grant1=%0d rsps=%0d expected 1 2", got1, nrsp);
    end
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    slv_rand = 1'b0; slv_wait = 1000; slv_rdata = 32'hFFFF_FFFF; slv_err = 1'b0;
    issue(1, 1'b0, 32'h70, 32'h0);
    tick(); req_valid[1] = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick();
      vectors++;
      if ({psel, penable, rsp_valid} !== 6'b11_0000) begin
        miscompares++;
        $display("FAIL to_wait_%0d: got %b expected 110000", t, {psel, penable, rsp_valid});
      end
    end
    tick();
    vectors++;
    if ({rsp_valid, rsp_slverr, rsp_rdata, psel, penable} !== {4'b0010, 1'b1, 32'h0, 2'b00}) begin
      miscompares++;
      $display("FAIL to_abort: got %h expected %h", {rsp_valid, rsp_slverr, rsp_rdata, psel, penable},
               {4'b0010, 1'b1, 32'h0, 2'b00});
    end
    slv_wait = 0;
    repeat (2) tick();
  endtask
`endif

  task automatic test_random();
    int          m_owner, m_ptr, g;
    bit          m_acc, m_write, e_sel, e_en, e_err;
    logic [31:0] m_addr, m_wdata, e_rdata;
    logic [N-1:0] pv_valid, pv_write, others, e_ready, e_rsp;
    logic [N*AW-1:0] pv_addr;
    logic [N*DW-1:0] pv_wdata;
    logic        pv_pready, pv_pslverr;
    logic [31:0] pv_prdata;
    bit          pend[N];
    bit          outst[N];
    bit          touched;
    do_reset();
    slv_rand = 1'b1;
    m_owner = -1; m_ptr = 0; m_acc = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
    e_rdata = '0; e_err = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; outst[i] = 1'b0; end
    pv_valid = req_valid; pv_write = req_write; pv_addr = req_addr; pv_wdata = req_wdata;
    pv_pready = pready; pv_pslverr = pslverr; pv_prdata = prdata;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      // model: one bus transfer at a time; a setup cycle, then access until ready
      e_ready = '0; e_rsp = '0; g = -1;
      if (m_owner < 0) begin
        g = pick(pv_valid, m_ptr);
      end else if (!m_acc) begin
        m_acc = 1'b1;
      end else if (pv_pready) begin
        e_rsp[m_owner] = 1'b1;
        e_rdata = m_write ? 32'h0 : pv_prdata;
        e_err   = pv_pslverr;
        others  = pv_valid;
        others[m_owner] = 1'b0;
        g = pick(others, m_ptr);
        if (g < 0) m_owner = -1;
      end
      if (g >= 0) begin
        m_owner = g; m_acc = 1'b0;
        m_addr  = pv_addr[g*AW +: AW];
        m_write = pv_write[g];
        m_wdata = m_write ? pv_wdata[g*DW +: DW] : 32'h0;
        e_ready[g] = 1'b1;
        m_ptr = (g + 1) % N;
      end
      e_sel = (m_owner >= 0);
      e_en  = e_sel && m_acc;
      vectors++;
      if ({psel, penable, req_ready, rsp_valid} !== {e_sel, e_en, e_ready, e_rsp}) begin
        miscompares++;
        $display("FAIL rnd_ctrl@%0d: got %b expected %b", cyc, {psel, penable, req_ready, rsp_valid},
                 {e_sel, e_en, e_ready, e_rsp});
      end
      if (e_sel) begin
        vectors++;
        if ({paddr, pwrite, pwdata} !== {m_addr, m_write, m_wdata}) begin
          miscompares++;
          $display("FAIL rnd_bus@%0d: got %h expected %h", cyc, {paddr, pwrite, pwdata}, {m_addr, m_write, m_wdata});
        end
      end
      if (e_rsp != '0) begin
        vectors++;
        if ({rsp_rdata, rsp_slverr} !== {e_rdata, e_err}) begin
          miscompares++;
          $display("FAIL rnd_rsp@%0d: got %h expected %h", cyc, {rsp_rdata, rsp_slverr}, {e_rdata, e_err});
        end
      end
      // requesters
      for (int i = 0; i < N; i++) begin
        touched = 1'b0;
        if (req_ready[i]) begin
          pend[i] = 1'b0; outst[i] = 1'b1; req_valid[i] = 1'b0; touched = 1'b1;
        end else if (pend[i] && $urandom_range(0, 24) == 0) begin
          pend[i] = 1'b0; req_valid[i] = 1'b0; touched = 1'b1;
        end
        if (rsp_valid[i]) outst[i] = 1'b0;
        if (!touched && !pend[i] && !outst[i] && $urandom_range(0, 2) == 0) begin
          issue(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
          pend[i] = 1'b1;
        end
      end
      pv_valid = req_valid; pv_write = req_write; pv_addr = req_addr; pv_wdata = req_wdata;
      pv_pready = pready; pv_pslverr = pslverr; pv_prdata = prdata;
    end
    slv_rand = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    test_reset();
    test_single_read();
    test_write_wait();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
